// File: rtl/lyap_pixel_scheduler_pkg.sv
// lyap_pkg: shared definitions for the Lyapunov pixel scheduler slice.
//   state_t     : scheduler FSM states (IDLE, RUN, DRAIN)
//   DEF_*       : default widths, worker count and frame dimensions
//   idx_width() : index width for an N-entry array (at least 1 bit)
package lyap_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int DEF_NW    = 4;
    localparam int DEF_XW    = 8;
    localparam int DEF_YW    = 8;
    localparam int DEF_RW    = 8;
    localparam int DEF_X_MAX = 159;
    localparam int DEF_Y_MAX = 119;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lyap_pixel_scheduler_if.sv
// lyap_pixel_scheduler_if: worker bus plus frame-buffer write port.
//   start/wx/wy     : scheduler -> workers, one-cycle start and shared coordinate
//   done/result     : workers -> scheduler, calc_end levels and packed results
//   wr_en/wr_x/wr_y/wr_data : scheduler -> frame buffer, valid + payload
//   wr_ready        : frame buffer -> scheduler
// master = scheduler side, slave = worker array / frame buffer side.
interface lyap_pixel_scheduler_if #(
    parameter int NW = 4,
    parameter int XW = 8,
    parameter int YW = 8,
    parameter int RW = 8
) ();
    logic [NW-1:0]    start;
    logic [XW-1:0]    wx;
    logic [YW-1:0]    wy;
    logic [NW-1:0]    done;
    logic [NW*RW-1:0] result;
    logic             wr_en;
    logic [XW-1:0]    wr_x;
    logic [YW-1:0]    wr_y;
    logic [RW-1:0]    wr_data;
    logic             wr_ready;

    modport master (
        output start, wx, wy, wr_en, wr_x, wr_y, wr_data,
        input  done, result, wr_ready
    );

    modport slave (
        input  start, wx, wy, wr_en, wr_x, wr_y, wr_data,
        output done, result, wr_ready
    );
endinterface

// File: rtl/lyap_pixel_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin arbiter.
//   req        : N request lines
//   ptr        : index where the search starts (highest priority)
//   gnt_onehot : one-hot grant, zero when no request
//   gnt_idx    : binary index of the granted line (0 when no request)
module rr_arbiter
    import lyap_pkg::*;
#(
    parameter int N = 4,
    localparam int IW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt_onehot,
    output logic [IW-1:0] gnt_idx
);

    int   idx;
    logic found;

    always_comb begin
        gnt_onehot = '0;
        gnt_idx    = '0;
        found      = 1'b0;
        idx        = 0;
        for (int k = 0; k < N; k++) begin
            // rotate the search so ptr is examined first, wrapping at N
            idx = int'(ptr) + k;
            if (idx >= N) idx = idx - N;
            if (!found && req[idx]) begin
                found           = 1'b1;
                gnt_onehot[idx] = 1'b1;
                gnt_idx         = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/lyap_pixel_scheduler.sv
// lyap_pixel_scheduler: walks the pixel raster, dispatches coordinates to NW
// compute workers and writes finished results to the frame buffer.
//   CLK, NRST  : clock, synchronous active-low reset
//   iGo        : start a frame (IDLE only)
//   iCont      : restart automatically after each frame
//   iAbort     : return to IDLE, dropping all in-flight work
//   bus        : worker start/coordinate/done/result and frame-buffer write port
//   oBusy      : high in RUN or DRAIN
//   oFrameDone : one-cycle pulse when a frame completes
//   oFrameCnt  : completed-frame counter (wraps)
module lyap_pixel_scheduler
    import lyap_pkg::*;
#(
    parameter int NW    = DEF_NW,
    parameter int XW    = DEF_XW,
    parameter int YW    = DEF_YW,
    parameter int RW    = DEF_RW,
    parameter int X_MAX = DEF_X_MAX,
    parameter int Y_MAX = DEF_Y_MAX
) (
    input  logic                     CLK,
    input  logic                     NRST,
    input  logic                     iGo,
    input  logic                     iCont,
    input  logic                     iAbort,
    lyap_pixel_scheduler_if.master   bus,
    output logic                     oBusy,
    output logic                     oFrameDone,
    output logic [7:0]               oFrameCnt
);

    localparam int IW = idx_width(NW);

    state_t          state_reg, state_next;
    logic [XW-1:0]   px_reg, px_next;
    logic [YW-1:0]   py_reg, py_next;
    logic [NW-1:0]   busy_reg, busy_next;
    logic [NW-1:0]   start_reg, start_next;
    logic [XW-1:0]   wx_reg, wx_next;
    logic [YW-1:0]   wy_reg, wy_next;
    logic [XW-1:0]   tag_x_reg [NW];
    logic [XW-1:0]   tag_x_next [NW];
    logic [YW-1:0]   tag_y_reg [NW];
    logic [YW-1:0]   tag_y_next [NW];
    logic            wr_en_reg, wr_en_next;
    logic [XW-1:0]   wr_x_reg, wr_x_next;
    logic [YW-1:0]   wr_y_reg, wr_y_next;
    logic [RW-1:0]   wr_data_reg, wr_data_next;
    logic [IW-1:0]   gidx_reg, gidx_next;
    logic [IW-1:0]   rr_reg, rr_next;
    logic            frame_done_reg, frame_done_next;
    logic [7:0]      frame_cnt_reg, frame_cnt_next;

    logic [NW-1:0]   qual;
    logic [NW-1:0]   gnt_onehot;
    logic [IW-1:0]   gnt_idx;
    logic            any_grant;
    logic [RW-1:0]   result_slice [NW];
    logic            free_found;
    logic [IW-1:0]   free_idx;

    // A worker's calc_end is still high from its previous job during its
    // start cycle, so only count done once the start pulse has gone.
    generate
        for (genvar gi = 0; gi < NW; gi++) begin : g_worker
            assign result_slice[gi] = bus.result[gi*RW +: RW];
            assign qual[gi]         = busy_reg[gi] & ~start_reg[gi] & bus.done[gi];
        end
    endgenerate

    rr_arbiter #(.N(NW)) u_arb (
        .req        (qual),
        .ptr        (rr_reg),
        .gnt_onehot (gnt_onehot),
        .gnt_idx    (gnt_idx)
    );

    assign any_grant = |gnt_onehot;

    // lowest-index idle worker, from the registered busy flags
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = NW - 1; i >= 0; i--) begin
            if (!busy_reg[i]) begin
                free_found = 1'b1;
                free_idx   = IW'(i);
            end
        end
    end

    always_comb begin
        state_next      = state_reg;
        px_next         = px_reg;
        py_next         = py_reg;
        busy_next       = busy_reg;
        start_next      = '0;
        wx_next         = wx_reg;
        wy_next         = wy_reg;
        tag_x_next      = tag_x_reg;
        tag_y_next      = tag_y_reg;
        wr_en_next      = wr_en_reg;
        wr_x_next       = wr_x_reg;
        wr_y_next       = wr_y_reg;
        wr_data_next    = wr_data_reg;
        gidx_next       = gidx_reg;
        rr_next         = rr_reg;
        frame_done_next = 1'b0;
        frame_cnt_next  = frame_cnt_reg;

        // Collection: release the worker on handshake; otherwise capture a
        // new grant. The else keeps a one-cycle gap between writes.
        if (wr_en_reg && bus.wr_ready) begin
            wr_en_next          = 1'b0;
            busy_next[gidx_reg] = 1'b0;
            rr_next             = (gidx_reg == IW'(NW - 1)) ? '0 : gidx_reg + 1'b1;
        end else if (!wr_en_reg && any_grant) begin
            wr_en_next   = 1'b1;
            gidx_next    = gnt_idx;
            wr_x_next    = tag_x_reg[gnt_idx];
            wr_y_next    = tag_y_reg[gnt_idx];
            wr_data_next = result_slice[gnt_idx];
        end

        case (state_reg)
            IDLE: begin
                if (iGo) begin
                    state_next = RUN;
                    px_next    = '0;
                    py_next    = '0;
                end
            end
            RUN: begin
                if (free_found) begin
                    start_next[free_idx] = 1'b1;
                    busy_next[free_idx]  = 1'b1;
                    tag_x_next[free_idx] = px_reg;
                    tag_y_next[free_idx] = py_reg;
                    wx_next              = px_reg;
                    wy_next              = py_reg;
                    if (px_reg == XW'(X_MAX)) begin
                        if (py_reg == YW'(Y_MAX)) begin
                            state_next = DRAIN;
                        end else begin
                            px_next = '0;
                            py_next = py_reg + 1'b1;
                        end
                    end else begin
                        px_next = px_reg + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (busy_reg == '0 && !wr_en_reg) begin
                    frame_done_next = 1'b1;
                    frame_cnt_next  = frame_cnt_reg + 1'b1;
                    px_next         = '0;
                    py_next         = '0;
                    state_next      = iCont ? RUN : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        // Abort drops everything in flight; late done levels from workers
        // are ignored because their busy flags are cleared here.
        if (iAbort) begin
            state_next      = IDLE;
            busy_next       = '0;
            start_next      = '0;
            wr_en_next      = 1'b0;
            px_next         = '0;
            py_next         = '0;
            rr_next         = rr_reg;
            frame_done_next = 1'b0;
            frame_cnt_next  = frame_cnt_reg;
        end
    end

    always_ff @(posedge CLK) begin
        if (!NRST) begin
            state_reg      <= IDLE;
            px_reg         <= '0;
            py_reg         <= '0;
            busy_reg       <= '0;
            start_reg      <= '0;
            wx_reg         <= '0;
            wy_reg         <= '0;
            for (int i = 0; i < NW; i++) begin
                tag_x_reg[i] <= '0;
                tag_y_reg[i] <= '0;
            end
            wr_en_reg      <= 1'b0;
            wr_x_reg       <= '0;
            wr_y_reg       <= '0;
            wr_data_reg    <= '0;
            gidx_reg       <= '0;
            rr_reg         <= '0;
            frame_done_reg <= 1'b0;
            frame_cnt_reg  <= '0;
        end else begin
            state_reg      <= state_next;
            px_reg         <= px_next;
            py_reg         <= py_next;
            busy_reg       <= busy_next;
            start_reg      <= start_next;
            wx_reg         <= wx_next;
            wy_reg         <= wy_next;
            tag_x_reg      <= tag_x_next;
            tag_y_reg      <= tag_y_next;
            wr_en_reg      <= wr_en_next;
            wr_x_reg       <= wr_x_next;
            wr_y_reg       <= wr_y_next;
            wr_data_reg    <= wr_data_next;
            gidx_reg       <= gidx_next;
            rr_reg         <= rr_next;
            frame_done_reg <= frame_done_next;
            frame_cnt_reg  <= frame_cnt_next;
        end
    end

    assign bus.start   = start_reg;
    assign bus.wx      = wx_reg;
    assign bus.wy      = wy_reg;
    assign bus.wr_en   = wr_en_reg;
    assign bus.wr_x    = wr_x_reg;
    assign bus.wr_y    = wr_y_reg;
    assign bus.wr_data = wr_data_reg;
    assign oBusy       = (state_reg != IDLE);
    assign oFrameDone  = frame_done_reg;
    assign oFrameCnt   = frame_cnt_reg;

endmodule

// File: tb/tb_lyap_pixel_scheduler.sv
// tb_lyap_pixel_scheduler: randomized self-checking bench for a 4x2 frame with
// two modelled workers. Every accepted write is checked against the pixel
// rule data = x + 4*y and a per-frame coverage map.
module tb_lyap_pixel_scheduler;

    localparam int NW = 2, XW = 8, YW = 8, RW = 8, X_MAX = 3, Y_MAX = 1;
    localparam int NPIX = (X_MAX + 1) * (Y_MAX + 1);

    logic       CLK = 1'b0;
    logic       NRST, iGo, iCont, iAbort;
    logic       oBusy, oFrameDone;
    logic [7:0] oFrameCnt;

    lyap_pixel_scheduler_if #(.NW(NW), .XW(XW), .YW(YW), .RW(RW)) bus ();

    lyap_pixel_scheduler #(
        .NW(NW), .XW(XW), .YW(YW), .RW(RW), .X_MAX(X_MAX), .Y_MAX(Y_MAX)
    ) dut (
        .CLK(CLK), .NRST(NRST), .iGo(iGo), .iCont(iCont), .iAbort(iAbort),
        .bus(bus), .oBusy(oBusy), .oFrameDone(oFrameDone), .oFrameCnt(oFrameCnt)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // ---------------- worker models ----------------
    int         lat [NW];
    bit         stale_mode = 1'b0;
    logic [NW-1:0] done_r;
    int         cnt_r [NW];
    logic [RW-1:0] res_r [NW];

    function automatic logic [RW-1:0] pixel_value(input int x, input int y);
        return RW'(x + 4 * y);
    endfunction

    always @(posedge CLK) begin
        for (int i = 0; i < NW; i++) begin
            if (!NRST) begin
                done_r[i] <= 1'b0;
                cnt_r[i]  <= 0;
                res_r[i]  <= '0;
            end else if (bus.start[i]) begin
                done_r[i] <= 1'b0;
                cnt_r[i]  <= lat[i];
                res_r[i]  <= pixel_value(int'(bus.wx), int'(bus.wy));
            end else if (cnt_r[i] != 0) begin
                cnt_r[i] <= cnt_r[i] - 1;
                if (cnt_r[i] == 1) done_r[i] <= 1'b1;
            end
        end
    end

    assign bus.done   = stale_mode ? '1 : done_r;
    assign bus.result = {res_r[1], res_r[0]};

    // ---------------- frame-buffer ready driver ----------------
    int ready_mode = 0;     // 0 always ready, 1 random, 2 five-cycle stall at write 3
    int stall_left = 0;
    bit stall_used = 1'b0;

    // ---------------- monitor / reference scoreboard ----------------
    bit seen [NPIX];
    int frame_writes = 0, total_writes = 0, done_cnt = 0, stall_cyc = 0;
    int disp_frame = 0, last_idx = -1, cyc = 0, go_cyc = -1, first_wr_cyc = -1;
    int disp_w [NW];
    bit out_of_order = 1'b0;
    logic [NW-1:0] prev_start = '0;
    logic [XW-1:0] prev_wx = '0, prev_x = '0;
    logic [YW-1:0] prev_wy = '0, prev_y = '0;
    logic [RW-1:0] prev_data = '0;
    logic prev_wr_en = 1'b0, prev_ready = 1'b0, prev_abort = 1'b0;

    task automatic clear_frame();
        for (int i = 0; i < NPIX; i++) seen[i] = 1'b0;
        frame_writes = 0;
        last_idx     = -1;
        disp_frame   = 0;
    endtask

    initial begin
        bus.wr_ready = 1'b1;
        forever begin
            @(posedge CLK);
            #1;
            case (ready_mode)
                1: bus.wr_ready = ($urandom_range(0, 3) != 0);
                2: begin
                    if (stall_left > 0) begin
                        bus.wr_ready = 1'b0;
                        stall_left--;
                    end else if (!stall_used && bus.wr_en && frame_writes == 2) begin
                        bus.wr_ready = 1'b0;
                        stall_left   = 4;
                        stall_used   = 1'b1;
                    end else begin
                        bus.wr_ready = 1'b1;
                    end
                end
                default: bus.wr_ready = 1'b1;
            endcase
        end
    end

    always @(negedge CLK) begin
        int idx;
        cyc++;
        if (NRST) begin
            if (iGo && !oBusy) go_cyc = cyc;
            if (bus.start != '0) begin
                disp_frame++;
                for (int i = 0; i < NW; i++) if (bus.start[i]) disp_w[i]++;
                check_eq("start_onehot", $countones(bus.start), 1);
                check_eq("start_back_to_back", int'(bus.start & prev_start), 0);
            end
            if (bus.wr_en && !prev_wr_en) begin
                check_eq("stale_capture", int'(prev_start != '0 && bus.wr_x == prev_wx
                                               && bus.wr_y == prev_wy), 0);
                if (first_wr_cyc < 0 && go_cyc >= 0) begin
                    first_wr_cyc = cyc;
                    check_eq("first_latency_ge3", int'((first_wr_cyc - go_cyc) >= 3), 1);
                end
            end
            if (prev_wr_en && !prev_ready && !prev_abort) begin
                stall_cyc++;
                check_eq("hold_en", int'(bus.wr_en), 1);
                check_eq("hold_x", int'(bus.wr_x), int'(prev_x));
                check_eq("hold_y", int'(bus.wr_y), int'(prev_y));
                check_eq("hold_data", int'(bus.wr_data), int'(prev_data));
            end
            if (bus.wr_en && bus.wr_ready && !iAbort) begin
                $display("WR x=%0d y=%0d data=%0d", bus.wr_x, bus.wr_y, bus.wr_data);
                check_eq("wr_in_range", int'(bus.wr_x <= X_MAX && bus.wr_y <= Y_MAX), 1);
                check_eq("wr_data", int'(bus.wr_data),
                         int'(pixel_value(int'(bus.wr_x), int'(bus.wr_y))));
                if (bus.wr_x <= X_MAX && bus.wr_y <= Y_MAX) begin
                    idx = int'(bus.wr_y) * (X_MAX + 1) + int'(bus.wr_x);
                    check_eq("wr_duplicate", int'(seen[idx]), 0);
                    seen[idx] = 1'b1;
                    if (idx < last_idx) out_of_order = 1'b1;
                    last_idx = idx;
                end
                frame_writes++;
                total_writes++;
            end
            if (oFrameDone) begin
                done_cnt++;
                $display("FRAME done count=%0d writes=%0d", oFrameCnt, frame_writes);
                check_eq("frame_writes", frame_writes, NPIX);
                for (int i = 0; i < NPIX; i++) check_eq("frame_cover", int'(seen[i]), 1);
                clear_frame();
            end
        end
        prev_start = bus.start;
        prev_wx    = bus.wx;
        prev_wy    = bus.wy;
        prev_wr_en = NRST ? bus.wr_en : 1'b0;
        prev_ready = bus.wr_ready;
        prev_x     = bus.wr_x;
        prev_y     = bus.wr_y;
        prev_data  = bus.wr_data;
        prev_abort = iAbort;
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic pulse_go();
        iGo = 1'b1;
        tick(1);
        iGo = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget);
        int n = 0;
        while (done_cnt < target && n < budget) begin
            tick(1);
            n++;
        end
        if (done_cnt < target) check_eq("timeout_frame_done", done_cnt, target);
    endtask

    task automatic run_frame(input int exp_cnt);
        int base = done_cnt;
        pulse_go();
        wait_done(base + 1, 600);
        tick(4);
        check_eq("frame_idle", int'(oBusy), 0);
        check_eq("frame_cnt", int'(oFrameCnt), exp_cnt);
    endtask

    initial begin
        int base, wbase, n;
        NRST = 1'b0; iGo = 1'b0; iCont = 1'b0; iAbort = 1'b0;
        lat[0] = 2; lat[1] = 2;
        disp_w[0] = 0; disp_w[1] = 0;
        clear_frame();
        tick(3);
        check_eq("rst_start", int'(bus.start), 0);
        check_eq("rst_wr_en", int'(bus.wr_en), 0);
        check_eq("rst_wxy", int'({bus.wx, bus.wy}), 0);
        check_eq("rst_wr_addr", int'({bus.wr_x, bus.wr_y, bus.wr_data}), 0);
        check_eq("rst_busy", int'(oBusy), 0);
        check_eq("rst_frame_done", int'(oFrameDone), 0);
        check_eq("rst_frame_cnt", int'(oFrameCnt), 0);
        NRST = 1'b1;
        tick(2);

        // basic frame
        wbase = total_writes;
        run_frame(1);
        check_eq("t1_writes", total_writes - wbase, NPIX);
        check_eq("t1_frames", done_cnt, 1);

        // stalled frame buffer at write 3
        ready_mode = 2; stall_cyc = 0; wbase = total_writes;
        run_frame(2);
        check_eq("t2_stall_cycles", stall_cyc, 5);
        check_eq("t2_writes", total_writes - wbase, NPIX);
        ready_mode = 0;

        // unequal latencies -> out-of-order writes
        lat[0] = 1; lat[1] = 10; out_of_order = 1'b0;
        disp_w[0] = 0; disp_w[1] = 0;
        run_frame(3);
        check_eq("t3_out_of_order", int'(out_of_order), 1);
        check_eq("t3_w0_more_dispatches", int'(disp_w[0] > disp_w[1]), 1);

        // continuous mode, 3 frames
        lat[0] = 2; lat[1] = 3; base = done_cnt; wbase = total_writes;
        iCont = 1'b1;
        pulse_go();
        wait_done(base + 2, 1500);
        iCont = 1'b0;
        wait_done(base + 3, 800);
        tick(10);
        check_eq("t4_frames", done_cnt - base, 3);
        check_eq("t4_writes", total_writes - wbase, 3 * NPIX);
        check_eq("t4_cnt", int'(oFrameCnt), 6);
        check_eq("t4_idle", int'(oBusy), 0);

        // abort after the 4th dispatch
        lat[0] = 3; lat[1] = 4; base = done_cnt;
        pulse_go();
        n = 0;
        while (disp_frame < 4 && n < 100) begin tick(1); n++; end
        check_eq("t5_reached_4_dispatches", int'(disp_frame >= 4), 1);
        iAbort = 1'b1;
        tick(1);
        iAbort = 1'b0;
        check_eq("t5_busy_after_abort", int'(oBusy), 0);
        check_eq("t5_wr_en_after_abort", int'(bus.wr_en), 0);
        check_eq("t5_start_after_abort", int'(bus.start), 0);
        clear_frame();
        tick(20);
        check_eq("t5_no_frame_done", done_cnt - base, 0);
        check_eq("t5_cnt_kept", int'(oFrameCnt), 6);
        check_eq("t5_no_writes_idle", frame_writes, 0);
        run_frame(7);

        // stale calc_end: done tied high
        stale_mode = 1'b1; ready_mode = 1;
        run_frame(8);
        stale_mode = 1'b0;

        // random latencies, random ready, stray iGo mid-frame
        for (int f = 0; f < 4; f++) begin
            lat[0] = $urandom_range(1, 8);
            lat[1] = $urandom_range(1, 8);
            base = done_cnt;
            pulse_go();
            tick($urandom_range(2, 6));
            pulse_go();
            wait_done(base + 1, 800);
            tick(4);
            check_eq("rand_one_frame", done_cnt - base, 1);
            check_eq("rand_cnt", int'(oFrameCnt), 9 + f);
        end
        ready_mode = 0;

        // reset mid-frame clears the counter
        lat[0] = 2; lat[1] = 2;
        pulse_go();
        tick(6);
        NRST = 1'b0;
        tick(2);
        check_eq("t7_rst_cnt", int'(oFrameCnt), 0);
        check_eq("t7_rst_busy", int'(oBusy), 0);
        check_eq("t7_rst_wr_en", int'(bus.wr_en), 0);
        NRST = 1'b1;
        clear_frame();
        tick(2);
        run_frame(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
